// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the stepper move sequencer: FSM state encoding,
// direction/mode line constants and the period clamp helper.
package step_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEL  = 3'd1,
        CRUISE = 3'd2,
        DECEL  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Level on the dir line for clockwise rotation.
    localparam logic DIR_CW    = 1'b1;
    // Level on the full_step line for full-step mode.
    localparam logic MODE_FULL = 1'b1;

    // Clamp arithmetic is done at this width; period widths up to 32 bits fit.
    localparam int CLAMP_W = 32;

    // Raise a period to at least the given floor.
    function automatic logic [CLAMP_W-1:0] clamp_period(
        input logic [CLAMP_W-1:0] value,
        input logic [CLAMP_W-1:0] floor
    );
        return (value < floor) ? floor : value;
    endfunction

endpackage

// File: rtl/step_period_timer.sv
// Loadable step-period down-counter. tick is high while the count sits at 1
// and the timer is running; on that edge the count reloads from period, so
// consecutive ticks are exactly 'period' cycles apart.
module step_period_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);
    logic [PERIOD_W-1:0] count_reg;

    assign tick = run && (count_reg == PERIOD_W'(1));

    // Count down while running; load at move start and reload on expiry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load || tick) begin
            count_reg <= period;
        end else if (run) begin
            count_reg <= count_reg - PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/step_move_scheduler.sv
// Move sequencer feeding the stepper phase state machine: accepts a move
// command, emits make_step strobes at the programmed period and tracks the
// absolute position. Build option: define STEP_RAMP_EN to enable the linear
// acceleration/deceleration ramp; without it moves run at the cruise period.
module step_move_scheduler
    import step_ctrl_pkg::*;
#(
    parameter int PERIOD_W   = 24,
    parameter int STEPS_W    = 16,
    parameter int POS_W      = 32,
    parameter int RAMP_DELTA = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [STEPS_W-1:0]      cmd_steps,
    input  logic                    cmd_dir,
    input  logic                    cmd_full,
    input  logic [PERIOD_W-1:0]     cfg_min_period,
    input  logic [PERIOD_W-1:0]     cfg_start_period,
    input  logic                    abort,
    output logic                    make_step,
    output logic                    dir,
    output logic                    full_step,
    output logic                    busy,
    output logic                    done,
    output logic [STEPS_W-1:0]      steps_left,
    output logic signed [POS_W-1:0] position
);
    // One extra bit so period +/- delta comparisons cannot overflow.
    localparam logic [PERIOD_W:0] DELTA_EXT = (PERIOD_W+1)'(RAMP_DELTA);

    state_t                  state_reg;
    logic                    dir_reg;
    logic                    full_reg;
    logic                    make_step_reg;
    logic                    done_reg;
    logic [STEPS_W-1:0]      steps_reg;
    logic signed [POS_W-1:0] pos_reg;
    logic [PERIOD_W-1:0]     min_period_reg;

    logic                    moving;
    logic                    accept;
    logic                    tick;
    logic [PERIOD_W-1:0]     min_clamped;
    logic [PERIOD_W-1:0]     start_clamped;
    logic [PERIOD_W-1:0]     timer_period;
    logic [STEPS_W-1:0]      steps_dec;
    logic [STEPS_W-1:0]      move_steps;
    logic signed [POS_W-1:0] step_mag;
    logic signed [POS_W-1:0] pos_stepped;
    state_t                  move_state;

    assign moving        = (state_reg == ACCEL) || (state_reg == CRUISE) || (state_reg == DECEL);
    assign accept        = (state_reg == IDLE) && cmd_valid;
    assign min_clamped   = PERIOD_W'(clamp_period(CLAMP_W'(cfg_min_period), CLAMP_W'(1)));
    assign start_clamped = PERIOD_W'(clamp_period(CLAMP_W'(cfg_start_period), CLAMP_W'(min_clamped)));
    assign steps_dec     = steps_reg - STEPS_W'(1);
    assign step_mag      = (full_reg == MODE_FULL) ? POS_W'(2) : POS_W'(1);
    assign pos_stepped   = (dir_reg == DIR_CW) ? pos_reg + step_mag : pos_reg - step_mag;

`ifdef STEP_RAMP_EN
    localparam state_t FIRST_MOVE_STATE = ACCEL;

    logic [STEPS_W-1:0]  ramp_cnt_reg;
    logic [STEPS_W-1:0]  ramp_after;
    logic [STEPS_W-1:0]  ramp_post;
    logic [PERIOD_W-1:0] start_period_reg;
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] period_after;
    state_t              state_after;

    // What one step leaves behind: next period, ramp count and moving state.
    always_comb begin
        period_after = period_reg;
        ramp_after   = ramp_cnt_reg;
        state_after  = state_reg;
        if (state_reg == ACCEL) begin
            ramp_after = ramp_cnt_reg + STEPS_W'(1);
            if ({1'b0, period_reg} <= {1'b0, min_period_reg} + DELTA_EXT) begin
                period_after = min_period_reg;
                state_after  = CRUISE;
            end else begin
                period_after = period_reg - DELTA_EXT[PERIOD_W-1:0];
            end
        end else if (state_reg == DECEL) begin
            ramp_after = (ramp_cnt_reg == '0) ? '0 : ramp_cnt_reg - STEPS_W'(1);
            if ({1'b0, period_reg} + DELTA_EXT >= {1'b0, start_period_reg}) begin
                period_after = start_period_reg;
            end else begin
                period_after = period_reg + DELTA_EXT[PERIOD_W-1:0];
            end
        end
        // Start slowing once the remaining steps only cover the ramp back down.
        if (((state_reg == ACCEL) || (state_reg == CRUISE)) && (steps_dec <= ramp_after)) begin
            state_after = DECEL;
        end
        if (steps_dec == '0) begin
            state_after = DONE;
        end
    end

    // Outcome of this edge while moving: a coincident step is counted before abort.
    always_comb begin
        move_steps = tick ? steps_dec : steps_reg;
        move_state = tick ? state_after : state_reg;
        ramp_post  = tick ? ramp_after : ramp_cnt_reg;
        if (abort && (move_state != DONE)) begin
            if (ramp_post == '0) begin
                move_state = DONE;
            end else begin
                move_state = DECEL;
                if (move_steps > ramp_post) begin
                    move_steps = ramp_post;
                end
            end
        end
    end

    assign timer_period = accept ? start_clamped : period_after;

    // Ramp bookkeeping: latch periods at accept, follow the ramp on every step.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ramp_cnt_reg     <= '0;
            start_period_reg <= PERIOD_W'(1);
            period_reg       <= PERIOD_W'(1);
        end else if (accept) begin
            ramp_cnt_reg     <= '0;
            start_period_reg <= start_clamped;
            period_reg       <= start_clamped;
        end else if (moving) begin
            ramp_cnt_reg <= ramp_post;
            if (tick) begin
                period_reg <= period_after;
            end
        end
    end
`else
    localparam state_t FIRST_MOVE_STATE = CRUISE;

    // Constant-speed move: stop when the count runs out or on abort.
    always_comb begin
        move_steps = tick ? steps_dec : steps_reg;
        move_state = state_reg;
        if (tick && (steps_dec == '0)) begin
            move_state = DONE;
        end
        if (abort) begin
            move_state = DONE;
        end
    end

    assign timer_period = accept ? min_clamped : min_period_reg;

    logic unused_ramp;
    assign unused_ramp = ^{cfg_start_period, start_clamped, DELTA_EXT};
`endif

    step_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .run    (moving),
        .period (timer_period),
        .tick   (tick)
    );

    // Move FSM: accept in IDLE, step on timer ticks, one-cycle done on exit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            dir_reg        <= DIR_CW;
            full_reg       <= MODE_FULL;
            make_step_reg  <= 1'b0;
            done_reg       <= 1'b0;
            steps_reg      <= '0;
            pos_reg        <= '0;
            min_period_reg <= PERIOD_W'(1);
        end else begin
            make_step_reg <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        dir_reg        <= cmd_dir;
                        full_reg       <= cmd_full;
                        steps_reg      <= cmd_steps;
                        min_period_reg <= min_clamped;
                        state_reg      <= (cmd_steps == '0) ? DONE : FIRST_MOVE_STATE;
                    end
                end
                ACCEL, CRUISE, DECEL: begin
                    if (tick) begin
                        make_step_reg <= 1'b1;
                        pos_reg       <= pos_stepped;
                    end
                    steps_reg <= move_steps;
                    state_reg <= move_state;
                end
                DONE: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_reg == IDLE);
    assign busy       = moving;
    assign make_step  = make_step_reg;
    assign done       = done_reg;
    assign dir        = dir_reg;
    assign full_step  = full_reg;
    assign steps_left = steps_reg;
    assign position   = pos_reg;

endmodule

// File: tb/tb_step_move_scheduler.sv
// Self-checking bench for step_move_scheduler. Each move is predicted by a
// timeline model (pulse edges, end edge, final position and steps) derived
// from the move rules, then compared against the observed strobes.
module tb_step_move_scheduler;
    localparam int PERIOD_W = 24;
    localparam int STEPS_W  = 16;
    localparam int POS_W    = 32;
    localparam int DELTA    = 1024;
`ifdef STEP_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [STEPS_W-1:0]      cmd_steps = '0;
    logic                    cmd_dir = 1'b0;
    logic                    cmd_full = 1'b0;
    logic [PERIOD_W-1:0]     cfg_min_period = '0;
    logic [PERIOD_W-1:0]     cfg_start_period = '0;
    logic                    abort = 1'b0;
    logic                    make_step;
    logic                    dir;
    logic                    full_step;
    logic                    busy;
    logic                    done;
    logic [STEPS_W-1:0]      steps_left;
    logic signed [POS_W-1:0] position;

    int     n_compared   = 0;
    int     n_mismatched = 0;
    int     exp_q[$];
    int     exp_end;
    int     exp_left;
    longint exp_pos = 0;

    always #5 clk = ~clk;

    step_move_scheduler #(
        .PERIOD_W   (PERIOD_W),
        .STEPS_W    (STEPS_W),
        .POS_W      (POS_W),
        .RAMP_DELTA (DELTA)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_steps        (cmd_steps),
        .cmd_dir          (cmd_dir),
        .cmd_full         (cmd_full),
        .cfg_min_period   (cfg_min_period),
        .cfg_start_period (cfg_start_period),
        .abort            (abort),
        .make_step        (make_step),
        .dir              (dir),
        .full_step        (full_step),
        .busy             (busy),
        .done             (done),
        .steps_left       (steps_left),
        .position         (position)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Timeline model: edges are counted from the accept edge (edge 0).
    // abort_edge is the edge at which abort is sampled high (0 = no abort).
    task automatic model_move(input int steps, input int min_p, input int start_p,
                              input int abort_edge, input bit d, input bit f);
        int min_c, start_c, per, rc, left, t;
        bit cruise, decel, aborted;
        min_c   = (min_p == 0) ? 1 : min_p;
        start_c = (start_p < min_c) ? min_c : start_p;
        per     = RAMP_EN ? start_c : min_c;
        cruise  = !RAMP_EN;
        decel   = 1'b0;
        aborted = 1'b0;
        rc      = 0;
        left    = steps;
        t       = 0;
        exp_end = 0;
        exp_q.delete();
        while (left > 0) begin
            if (!aborted && abort_edge > 0 && abort_edge < t + per) begin
                aborted = 1'b1;
                if (!RAMP_EN || rc == 0) begin
                    exp_end = abort_edge;
                    break;
                end
                if (left > rc) left = rc;
                decel = 1'b1;
            end
            t += per;
            exp_q.push_back(t);
            left--;
            exp_pos += (f ? 2 : 1) * (d ? 1 : -1);
            if (RAMP_EN) begin
                if (decel) begin
                    if (rc > 0) rc--;
                    per = (per + DELTA > start_c) ? start_c : per + DELTA;
                end else begin
                    if (!cruise) begin
                        rc++;
                        per -= DELTA;
                        if (per <= min_c) begin
                            per    = min_c;
                            cruise = 1'b1;
                        end
                    end
                    if (left <= rc) decel = 1'b1;
                end
            end
            if (left == 0) begin
                exp_end = t;
                break;
            end
            if (!aborted && abort_edge == t) begin
                aborted = 1'b1;
                if (!RAMP_EN || rc == 0) begin
                    exp_end = t;
                    break;
                end
                if (left > rc) left = rc;
                decel = 1'b1;
            end
        end
        exp_left = left;
    endtask

    task automatic run_move(input string name, input int steps, input int min_p, input int start_p,
                            input int abort_edge, input bit d, input bit f);
        int got_q[$];
        int got_done;
        int hold_err;
        model_move(steps, min_p, start_p, abort_edge, d, f);
        check_eq({name, " ready"}, cmd_ready, 1);
        cmd_valid        = 1'b1;
        cmd_steps        = STEPS_W'(steps);
        cmd_dir          = d;
        cmd_full         = f;
        cfg_min_period   = PERIOD_W'(min_p);
        cfg_start_period = PERIOD_W'(start_p);
        @(posedge clk); #1;
        // Scramble command inputs: the move must run on the latched values.
        cmd_valid        = 1'b0;
        cmd_steps        = STEPS_W'($urandom);
        cmd_dir          = 1'($urandom);
        cmd_full         = 1'($urandom);
        cfg_min_period   = PERIOD_W'($urandom_range(1, 3));
        cfg_start_period = PERIOD_W'($urandom_range(1, 3));
        check_eq({name, " busy_at_accept"}, busy, (steps != 0) ? 1 : 0);
        check_eq({name, " dir_latched"}, dir, d);
        check_eq({name, " full_latched"}, full_step, f);
        got_done = -1;
        hold_err = 0;
        for (int k = 1; k <= exp_end + 20; k++) begin
            abort = (k == abort_edge);
            @(posedge clk); #1;
            if (make_step) got_q.push_back(k);
            if (busy && (dir != d || full_step != f)) hold_err++;
            if (done) begin
                got_done = k;
                break;
            end
        end
        abort = 1'b0;
        check_eq({name, " pulse_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s pulse%0d_edge", name, i), got_q[i], exp_q[i]);
        end
        check_eq({name, " done_edge"}, got_done, exp_end + 1);
        check_eq({name, " position"}, position, exp_pos);
        check_eq({name, " steps_left"}, steps_left, exp_left);
        check_eq({name, " hold_errors"}, hold_err, 0);
        check_eq({name, " busy_after"}, busy, 0);
        $display("move %s: steps=%0d min=%0d start=%0d abort@%0d dir=%0d full=%0d -> pulses=%0d done@%0d pos=%0d left=%0d",
                 name, steps, min_p, start_p, abort_edge, d, f, got_q.size(), got_done, position, steps_left);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset make_step", make_step, 0);
        check_eq("reset busy", busy, 0);
        check_eq("reset done", done, 0);
        check_eq("reset steps_left", steps_left, 0);
        check_eq("reset position", position, 0);
        check_eq("reset dir", dir, 1);
        check_eq("reset full_step", full_step, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("reset cmd_ready", cmd_ready, 1);

        run_move("t1_cw_full", 4, 10, 10, 0, 1'b1, 1'b1);
        run_move("t2_zero", 0, 10, 10, 0, 1'b1, 1'b1);
        run_move("t4_half_ccw", 3, 6, 6, 0, 1'b0, 1'b0);
        run_move("t3_ramp", 20, 1000, 5000, 0, 1'b1, 1'b1);
        run_move("t5_abort", 106, 1000, 5000, 16356, 1'b1, 1'b0);
        run_move("t_min_zero", 3, 0, 0, 0, 1'b1, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_move($sformatf("rnd%0d", i), int'($urandom_range(0, 8)), int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 30)),
                     ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a move.
        cmd_valid        = 1'b1;
        cmd_steps        = STEPS_W'(50);
        cmd_dir          = 1'b0;
        cmd_full         = 1'b0;
        cfg_min_period   = PERIOD_W'(3);
        cfg_start_period = PERIOD_W'(3);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("t6 busy_before_rst", busy, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("t6 make_step", make_step, 0);
        check_eq("t6 busy", busy, 0);
        check_eq("t6 position", position, 0);
        check_eq("t6 steps_left", steps_left, 0);
        check_eq("t6 dir", dir, 1);
        check_eq("t6 full_step", full_step, 1);
        rst = 1'b1;
        exp_pos = 0;
        @(posedge clk); #1;
        check_eq("t6 cmd_ready", cmd_ready, 1);
        run_move("t6_after_rst", 2, 5, 5, 0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
